// File: rtl/vivaldi_pkg.sv
// vivaldi_pkg: shared types and constants for the wave sequencer and its note table
package vivaldi_pkg;
  localparam int PHASE_W_DEF = 24;
  localparam int DUR_W_DEF = 16;
  localparam int GAIN_W_DEF = 7;
  localparam int GAIN_MAX_PCT = 100;
  typedef enum logic [2:0] {
    SINE = 3'd0,
    SQUARE = 3'd1,
    TRIANGLE = 3'd2,
    SAWTOOTH = 3'd3,
    NOISE = 3'd4,
    REST = 3'd5
  } wave_e;
  typedef struct packed {
    logic [2:0] wave;
    logic [PHASE_W_DEF-1:0] phase_inc;
    logic [GAIN_W_DEF-1:0] gain;
    logic [DUR_W_DEF-1:0] dur;
    logic last;
  } seq_entry_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_DONE} seq_state_e;
  function automatic logic is_rest(input logic [2:0] w);
    return w >= REST;
  endfunction
  function automatic logic [GAIN_W_DEF-1:0] clamp_gain(input logic [GAIN_W_DEF-1:0] g);
    return (g > GAIN_W_DEF'(GAIN_MAX_PCT)) ? GAIN_W_DEF'(GAIN_MAX_PCT) : g;
  endfunction
endpackage

// File: rtl/wave_seq_table.sv
// wave_seq_table: note table with registered read, gain clamped on write, last flags reset to 1
module wave_seq_table
  import vivaldi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  input  seq_entry_t               wdata_i,
  output seq_entry_t               rdata_o
);
  seq_entry_t mem_q [DEPTH];
  seq_entry_t wd;
  seq_entry_t rd_q;
  logic [DEPTH-1:0] last_q;
  always_comb begin
    wd = wdata_i;
    wd.gain = clamp_gain(wdata_i.gain);
  end
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wd;
    rd_q <= mem_q[raddr_i];
    rd_q.last <= last_q[raddr_i];
  end
  // only the last flags reset, so an unprogrammed table ends after one entry
  always_ff @(posedge clk_i) begin
    if (!rst_ni) last_q <= '1;
    else if (we_i) last_q[waddr_i] <= wdata_i.last;
  end
  assign rdata_o = rd_q;
endmodule

// File: rtl/wave_sequencer.sv
// wave_sequencer: walks the note table and drives oscillator select, phase increment and gain
module wave_sequencer
  import vivaldi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DUR_W = DUR_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_we_i,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr_i,
  input  logic [2:0]               cfg_wave_i,
  input  logic [PHASE_W-1:0]       cfg_phase_inc_i,
  input  logic [GAIN_W-1:0]        cfg_gain_i,
  input  logic [DUR_W-1:0]         cfg_dur_i,
  input  logic                     cfg_last_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     loop_i,
  input  logic                     sample_tick_i,
  output logic                     busy_o,
  output logic                     note_on_o,
  output logic [2:0]               wave_sel_o,
  output logic [PHASE_W-1:0]       phase_inc_o,
  output logic [GAIN_W-1:0]        gain_o,
  output logic [$clog2(DEPTH)-1:0] note_idx_o,
  output logic                     done_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] LOAD = ST_LOAD;
  localparam logic [1:0] PLAY = ST_PLAY;
  localparam logic [1:0] DONE = ST_DONE;
  logic [1:0] state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, nidx_q, nidx_d;
  logic [DUR_W-1:0] cnt_q, cnt_d, dur_q, dur_d;
  logic cur_last_q, cur_last_d, on_q, on_d, done_q, done_d;
  logic [2:0] wave_q, wave_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic clr, seq_end;
  seq_entry_t rd, wdata;
  assign wdata = '{wave: cfg_wave_i, phase_inc: cfg_phase_inc_i, gain: cfg_gain_i,
                   dur: cfg_dur_i, last: cfg_last_i};
  // read address follows the next index so the entry is ready during LOAD
  wave_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (cfg_we_i && state_q == IDLE && rst_ni),
    .waddr_i (cfg_addr_i),
    .raddr_i (idx_d),
    .wdata_i (wdata),
    .rdata_o (rd)
  );
  assign seq_end = (state_q == LOAD ? rd.last : cur_last_q) || idx_q == AW'(DEPTH - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    dur_d = dur_q;
    cur_last_d = cur_last_q;
    on_d = on_q;
    wave_d = wave_q;
    phase_d = phase_q;
    gain_d = gain_q;
    nidx_d = nidx_q;
    done_d = 1'b0;
    clr = 1'b0;
    if (state_q == IDLE) begin
      if (start_i && !stop_i) begin
        state_d = LOAD;
        idx_d = '0;
      end
    end else if (stop_i) begin
      state_d = IDLE;
      idx_d = '0;
      clr = 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == LOAD && rd.dur != '0) begin
      state_d = PLAY;
      cnt_d = '0;
      dur_d = rd.dur;
      cur_last_d = rd.last;
      wave_d = rd.wave;
      phase_d = rd.phase_inc;
      gain_d = is_rest(rd.wave) ? '0 : rd.gain;
      nidx_d = idx_q;
      on_d = !is_rest(rd.wave);
    end else if (state_q == LOAD || (sample_tick_i && cnt_q == dur_q - 1'b1)) begin
      // end of note, or a zero-duration entry being skipped
      on_d = 1'b0;
      if (seq_end && !loop_i) begin
        state_d = DONE;
        done_d = 1'b1;
        idx_d = '0;
        clr = 1'b1;
      end else begin
        state_d = LOAD;
        idx_d = seq_end ? '0 : idx_q + 1'b1;
      end
    end else if (sample_tick_i) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (clr) begin
      on_d = 1'b0;
      wave_d = '0;
      phase_d = '0;
      gain_d = '0;
      nidx_d = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      dur_q <= '0;
      cur_last_q <= 1'b0;
      on_q <= 1'b0;
      wave_q <= '0;
      phase_q <= '0;
      gain_q <= '0;
      nidx_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      dur_q <= dur_d;
      cur_last_q <= cur_last_d;
      on_q <= on_d;
      wave_q <= wave_d;
      phase_q <= phase_d;
      gain_q <= gain_d;
      nidx_q <= nidx_d;
      done_q <= done_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign note_on_o = on_q;
  assign wave_sel_o = wave_q;
  assign phase_inc_o = phase_q;
  assign gain_o = gain_q;
  assign note_idx_o = nidx_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: randomized stimulus against a behavioural note-table model plus directed note checks
module tb_wave_sequencer;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic cfg_we_i = 1'b0;
  logic [3:0] cfg_addr_i = '0;
  logic [2:0] cfg_wave_i = '0;
  logic [23:0] cfg_phase_inc_i = '0;
  logic [6:0] cfg_gain_i = '0;
  logic [15:0] cfg_dur_i = '0;
  logic cfg_last_i = 1'b0;
  logic start_i = 1'b0, stop_i = 1'b0, loop_i = 1'b0, sample_tick_i = 1'b1;
  logic busy_o, note_on_o, done_o;
  logic [2:0] wave_sel_o;
  logic [23:0] phase_inc_o;
  logic [6:0] gain_o;
  logic [3:0] note_idx_o;
  int checks = 0, failures = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  wave_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_wave_i(cfg_wave_i), .cfg_phase_inc_i(cfg_phase_inc_i), .cfg_gain_i(cfg_gain_i),
    .cfg_dur_i(cfg_dur_i), .cfg_last_i(cfg_last_i), .start_i(start_i), .stop_i(stop_i),
    .loop_i(loop_i), .sample_tick_i(sample_tick_i), .busy_o(busy_o), .note_on_o(note_on_o),
    .wave_sel_o(wave_sel_o), .phase_inc_o(phase_inc_o), .gain_o(gain_o),
    .note_idx_o(note_idx_o), .done_o(done_o)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // behavioural model: table arrays, a ticks-remaining count and the presented note
  int m_mode = 0, m_idx = 0, m_left = 0;
  logic e_busy = 0, e_on = 0, e_done = 0;
  logic [2:0] e_wave = 0;
  logic [23:0] e_ph = 0;
  logic [6:0] e_gain = 0;
  logic [3:0] e_nidx = 0;
  logic [2:0] t_wave [16];
  logic [23:0] t_ph [16];
  logic [6:0] t_gain [16];
  logic [15:0] t_dur [16];
  bit t_last [16];
  task automatic m_zero();
    e_on = 0; e_wave = 0; e_ph = 0; e_gain = 0; e_nidx = 0;
  endtask
  task automatic m_advance();
    bit fin_seq = t_last[m_idx] || m_idx == 15;
    if (fin_seq && !loop_i) begin
      m_mode = 3; e_done = 1; m_idx = 0; m_zero();
    end else begin
      m_idx = fin_seq ? 0 : m_idx + 1; m_mode = 1;
    end
  endtask
  always @(posedge clk) begin
    if (!rst_ni) begin
      m_mode = 0; m_idx = 0; e_done = 0; m_zero();
      for (int i = 0; i < 16; i++) t_last[i] = 1;
    end else begin
      e_done = 0;
      if (m_mode == 0) begin
        if (cfg_we_i) begin
          t_wave[cfg_addr_i] = cfg_wave_i; t_ph[cfg_addr_i] = cfg_phase_inc_i;
          t_gain[cfg_addr_i] = cfg_gain_i > 7'd100 ? 7'd100 : cfg_gain_i;
          t_dur[cfg_addr_i] = cfg_dur_i; t_last[cfg_addr_i] = cfg_last_i;
        end
        if (start_i && !stop_i) begin m_mode = 1; m_idx = 0; end
      end else if (stop_i) begin
        m_mode = 0; m_idx = 0; m_zero();
      end else if (m_mode == 1) begin
        if (t_dur[m_idx] == 0) m_advance();
        else begin
          m_mode = 2; m_left = int'(t_dur[m_idx]);
          e_wave = t_wave[m_idx]; e_ph = t_ph[m_idx]; e_nidx = 4'(m_idx);
          e_on = t_wave[m_idx] < 3'd5;
          e_gain = t_wave[m_idx] < 3'd5 ? t_gain[m_idx] : 7'd0;
        end
      end else if (m_mode == 2) begin
        if (sample_tick_i) begin
          m_left--;
          if (m_left == 0) begin e_on = 0; m_advance(); end
        end
      end else m_mode = 0;
    end
    e_busy = m_mode != 0;
  end
  always @(negedge clk)
    if (chk_en)
      chk("model", 64'({busy_o, note_on_o, wave_sel_o, phase_inc_o, gain_o, note_idx_o, done_o}),
          64'({e_busy, e_on, e_wave, e_ph, e_gain, e_nidx, e_done}));
  int r_wave[$], r_len[$], r_idx[$], r_gain[$], r_gap[$], idx_seq[$];
  int done_cnt, rest_bad, rest_cyc;
  function automatic int qget(input int q[$], input int i);
    return i < q.size() ? q[i] : -1;
  endfunction
  task automatic wr(input int a, input int w, input int ph, input int g, input int d, input int l);
    cfg_we_i = 1; cfg_addr_i = 4'(a); cfg_wave_i = 3'(w); cfg_phase_inc_i = 24'(ph);
    cfg_gain_i = 7'(g); cfg_dur_i = 16'(d); cfg_last_i = 1'(l);
    @(negedge clk);
    cfg_we_i = 0;
  endtask
  task automatic go();
    start_i = 1;
    @(negedge clk);
    start_i = 0;
  endtask
  task automatic stop_pulse();
    stop_i = 1;
    @(negedge clk);
    stop_i = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 300) begin @(negedge clk); n++; end
    if (busy_o) chk("idle_timeout", 64'(busy_o), 64'(0));
  endtask
  task automatic observe(input int n);
    int gap = 0;
    bit prev = 0;
    r_wave.delete(); r_len.delete(); r_idx.delete(); r_gain.delete(); r_gap.delete(); idx_seq.delete();
    done_cnt = 0; rest_bad = 0; rest_cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (note_on_o) begin
        if (!prev) begin
          r_wave.push_back(int'(wave_sel_o)); r_len.push_back(1); r_idx.push_back(int'(note_idx_o));
          r_gain.push_back(int'(gain_o)); r_gap.push_back(gap);
        end else r_len[r_len.size()-1]++;
        gap = 0;
      end else gap++;
      prev = note_on_o;
      if (done_o) done_cnt++;
      if (busy_o && !done_o && (idx_seq.size() == 0 || idx_seq[idx_seq.size()-1] != int'(note_idx_o)))
        idx_seq.push_back(int'(note_idx_o));
      if (wave_sel_o >= 3'd5) begin
        rest_cyc++;
        if (gain_o != 0 || note_on_o) rest_bad++;
      end
    end
  endtask
  initial begin
    int bad;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("reset_outputs", 64'({busy_o, note_on_o, wave_sel_o, phase_inc_o, gain_o, note_idx_o, done_o}), 64'(0));
    rst_ni = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) wr(i, i, 1000 * (i + 1), 80, 4, i == 4);
    go();
    chk("start_latency_load", 64'({busy_o, note_on_o}), 64'(2'b10));
    observe(30);
    chk("t1_runs", 64'(r_wave.size()), 64'(5));
    for (int i = 0; i < 5; i++) begin
      chk("t1_wave", 64'(qget(r_wave, i)), 64'(i));
      chk("t1_len", 64'(qget(r_len, i)), 64'(4));
      chk("t1_gap", 64'(qget(r_gap, i)), 64'(i == 0 ? 0 : 1));
    end
    chk("t1_gain", 64'(qget(r_gain, 2)), 64'(80));
    chk("t1_done_cnt", 64'(done_cnt), 64'(1));
    chk("t1_busy_end", 64'(busy_o), 64'(0));
    wr(0, 0, 1000, 120, 2, 1);
    go();
    observe(8);
    chk("t2_gain_clamp", 64'(qget(r_gain, 0)), 64'(100));
    chk("t2_done", 64'(done_cnt), 64'(1));
    wr(0, 1, 500, 50, 2, 0);
    wr(1, 2, 600, 50, 0, 0);
    wr(2, 3, 700, 50, 2, 1);
    go();
    observe(12);
    chk("t3_runs", 64'(r_idx.size()), 64'(2));
    chk("t3_idx0", 64'(qget(r_idx, 0)), 64'(0));
    chk("t3_idx1", 64'(qget(r_idx, 1)), 64'(2));
    chk("t3_idx_seq", 64'(qget(idx_seq, 1)), 64'(2));
    chk("t3_skip_gap", 64'(qget(r_gap, 1)), 64'(2));
    wr(0, 0, 100, 60, 2, 0);
    wr(1, 1, 200, 60, 3, 1);
    loop_i = 1;
    go();
    observe(20);
    bad = 0;
    for (int i = 0; i < r_idx.size(); i++) if (r_idx[i] != i % 2) bad++;
    chk("t4_alternate", 64'(bad), 64'(0));
    chk("t4_enough_runs", 64'(r_idx.size() >= 4), 64'(1));
    chk("t4_no_done", 64'(done_cnt), 64'(0));
    chk("t4_busy_before_stop", 64'(busy_o), 64'(1));
    stop_pulse();
    chk("t4_stop_outputs", 64'({busy_o, note_on_o, wave_sel_o, phase_inc_o, gain_o, note_idx_o, done_o}), 64'(0));
    loop_i = 0;
    observe(3);
    chk("t4_stop_no_done", 64'(done_cnt), 64'(0));
    wr(0, 1, 300, 70, 3, 1);
    loop_i = 1;
    go();
    @(negedge clk);
    wr(0, 2, 999, 10, 5, 1);
    stop_pulse();
    loop_i = 0;
    go();
    observe(8);
    chk("t5_old_wave", 64'(qget(r_wave, 0)), 64'(1));
    chk("t5_old_len", 64'(qget(r_len, 0)), 64'(3));
    chk("t5_old_gain", 64'(qget(r_gain, 0)), 64'(70));
    wr(0, 0, 100, 40, 2, 0);
    wr(1, 6, 200, 50, 3, 0);
    wr(2, 1, 300, 40, 2, 1);
    go();
    observe(15);
    chk("t6_runs", 64'(r_wave.size()), 64'(2));
    chk("t6_after_rest", 64'(qget(r_wave, 1)), 64'(1));
    chk("t6_rest_gap", 64'(qget(r_gap, 1)), 64'(5));
    chk("t6_rest_silent", 64'(rest_bad), 64'(0));
    chk("t6_rest_seen", 64'(rest_cyc >= 3), 64'(1));
    chk("t6_idx_seq", 64'(qget(idx_seq, 1)), 64'(1));
    go();
    @(negedge clk);
    rst_ni = 0;
    @(negedge clk);
    rst_ni = 1;
    chk("reset_midplay", 64'({busy_o, note_on_o, done_o}), 64'(0));
    for (int i = 0; i < 16; i++)
      wr(i, $urandom_range(7), $urandom, $urandom_range(127), $urandom_range(4, 1), $urandom_range(3) == 0);
    for (int c = 0; c < 4000; c++) begin
      rst_ni = $urandom_range(399) != 0;
      stop_i = $urandom_range(59) == 0;
      start_i = $urandom_range(9) == 0;
      sample_tick_i = 1'($urandom_range(1));
      if ($urandom_range(49) == 0) loop_i = 1'($urandom_range(1));
      cfg_we_i = !start_i && $urandom_range(5) == 0;
      cfg_addr_i = 4'($urandom_range(15));
      cfg_wave_i = 3'($urandom_range(7));
      cfg_phase_inc_i = 24'($urandom);
      cfg_gain_i = 7'($urandom_range(127));
      cfg_dur_i = 16'($urandom_range(4));
      cfg_last_i = $urandom_range(3) == 0;
      @(negedge clk);
    end
    rst_ni = 1; cfg_we_i = 0; start_i = 0; loop_i = 0;
    stop_pulse();
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
- Step sequencer that drives the vivaldi oscillator/gain datapath from a small programmable note table.
- Each table entry holds a waveform select, a phase increment, a gain percentage and a duration counted in output samples.
- Once started, it walks the table and presents one entry at a time to the oscillator, advancing on sample ticks from the sample output path.
- It replaces the bench-driven select_*/set_gain_percent/write_next_num_secs sequencing with hardware.

Parameters:
- DEPTH, 16, number of table entries (power of 2, >= 2).
- PHASE_W, 24, width of the oscillator phase increment.
- DUR_W, 16, width of the note duration in samples.
- GAIN_W, 7, width of the gain percent field.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset: synchronous, active-low.
- cfg_we_i  in  1  table write strobe.
- cfg_addr_i  in  $clog2(DEPTH)  table write address.
- cfg_wave_i  in  3  waveform code: 0 sine, 1 square, 2 triangle, 3 sawtooth, 4 noise, 5-7 rest.
- cfg_phase_inc_i  in  PHASE_W  phase increment.
- cfg_gain_i  in  GAIN_W  gain in percent.
- cfg_dur_i  in  DUR_W  duration in samples; 0 means skip the entry.
- cfg_last_i  in  1  marks the entry as end of sequence.
- start_i  in  1  begin playback at entry 0.
- stop_i  in  1  abort playback.
- loop_i  in  1  at end of sequence, restart at entry 0 instead of finishing.
- sample_tick_i  in  1  one-cycle pulse per output sample consumed.
- busy_o  out  1  high while state is not IDLE.
- note_on_o  out  1  oscillator enable.
- wave_sel_o  out  3  waveform select to the oscillator.
- phase_inc_o  out  PHASE_W  phase increment to the oscillator.
- gain_o  out  GAIN_W  gain percent to the gain stage.
- note_idx_o  out  $clog2(DEPTH)  current entry index.
- done_o  out  1  one-cycle pulse at normal end of sequence.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; index 0.
  - Table contents are not reset; each table entry's last flag resets to 1, so an unprogrammed table is a one-entry sequence.
- Table writes:
  - Accepted only in IDLE; writes while busy are dropped.
  - cfg_gain_i > 100 is stored as 100 (clamp at write).
- States: IDLE, LOAD, PLAY, DONE.
- IDLE:
  - If start_i=1 and stop_i=0, go to LOAD with index 0.
  - busy_o rises the cycle after start.
- LOAD (exactly one cycle):
  - Registered table read of the current index.
  - Next cycle, the entry is latched onto wave_sel_o, phase_inc_o, gain_o and note_idx_o; the duration counter is cleared.
  - If dur=0, do not enter PLAY; advance as at end of note, and note_on_o stays low.
  - Otherwise enter PLAY with note_on_o=1, unless the wave code is 5-7; in that case note_on_o=0 and gain_o=0 (rest), and the duration is still counted.
- PLAY:
  - Each sample_tick_i increments the counter.
  - On the tick where counter == dur-1, the note ends:
    - If the entry is not last and index < DEPTH-1: index+1, go to LOAD.
    - Otherwise, if loop_i=1: index 0, go to LOAD.
    - Otherwise go to DONE.
  - note_on_o drops to 0 during the LOAD cycle between notes.
- DONE:
  - done_o=1 for one cycle.
  - All note outputs are zeroed; next state is IDLE.
- sample_tick_i during LOAD or DONE is ignored and not counted.
- stop_i in any non-IDLE state: next cycle IDLE; all outputs 0; index 0; no done_o.
- Simultaneous events:
  - stop_i overrides start_i and any tick.
  - start_i while busy is ignored.
- loop_i is sampled only at end of sequence.
- Reset mid-playback behaves as stop, with no done_o.
- Latency:
  - start_i at cycle t gives note outputs valid at t+2.
  - A note of duration D holds its outputs for exactly D ticks.

Decomposition:
- vivaldi_pkg:
  - wave_e enum (SINE=0, SQUARE, TRIANGLE, SAWTOOTH, NOISE, REST codes).
  - seq_entry_t packed struct {wave, phase_inc, gain, dur, last}.
  - GAIN_MAX_PCT=100.
  - seq_state_e.
- One sub-module, wave_seq_table: a DEPTH x seq_entry_t single-write, registered-read memory with a write-side gain clamp.

Test Plan:
- Program 5 entries (sine, square, triangle, sawtooth, noise), each dur=4, gain 80, last on entry 4, loop=0; tick every cycle -> wave_sel_o steps 0,1,2,3,4; each held 4 ticks; note_on_o low one cycle between notes; done_o pulses once; busy_o then low.
- cfg_gain_i=120 written, then played -> gain_o=100.
- Entry 1 dur=0 in a 3-entry table -> entry 1 is never presented with note_on_o=1; note_idx_o goes 0 -> 2.
- 2-entry table, loop=1, 20 ticks -> indices alternate 0,1,0,...; no done_o; stop_i -> all outputs 0 the next cycle; no done_o.
- cfg write to entry 0 while playing -> table unchanged; after a restart, the old values play.
- Wave code 6 with dur=3 -> note_on_o=0 and gain_o=0 for 3 ticks, then the next entry plays.
